// File: rtl/datapath_unit.sv
// Accumulator-style datapath with an 8-bit common bus, a 256x8 memory, a simple ALU and a one-hot
// sequence counter. Each register has its own clear/load/increment controls. The bus is
// combinational and every other output is registered.
module datapath_unit (
  input  logic       i_clk,
  input  logic       i_rst,
  // Register controls
  input  logic       i_load_ar,
  input  logic       i_load_pc,
  input  logic       i_load_dr,
  input  logic       i_load_ac,
  input  logic       i_load_ir,
  input  logic       i_load_tr,
  input  logic       i_clear_ar,
  input  logic       i_clear_pc,
  input  logic       i_clear_dr,
  input  logic       i_clear_ac,
  input  logic       i_clear_tr,
  input  logic       i_inc_ar,
  input  logic       i_inc_pc,
  input  logic       i_inc_dr,
  input  logic       i_inc_ac,
  input  logic       i_inc_tr,
  // Sequencing, memory and bus control
  input  logic       i_seq_counter_reset,
  input  logic       i_memory_read,
  input  logic       i_memory_write,
  input  logic [2:0] i_bus_selectors,
  input  logic       i_alu_enable,
  input  logic [2:0] i_alu_mode,
  // Memory preload port, only active during reset
  input  logic       i_prog_we,
  input  logic [7:0] i_prog_addr,
  input  logic [7:0] i_prog_data,
  // Observed state
  output logic [7:0] o_t,
  output logic [7:0] o_ir,
  output logic [7:0] o_ac,
  output logic [7:0] o_pc,
  output logic [7:0] o_ar,
  output logic [7:0] o_dr,
  output logic       o_e,
  output logic [7:0] o_bus
);

  // Bus source encodings
  localparam logic [2:0] SelZero = 3'd0;
  localparam logic [2:0] SelAr   = 3'd1;
  localparam logic [2:0] SelPc   = 3'd2;
  localparam logic [2:0] SelDr   = 3'd3;
  localparam logic [2:0] SelAc   = 3'd4;
  localparam logic [2:0] SelIr   = 3'd5;
  localparam logic [2:0] SelTr   = 3'd6;
  localparam logic [2:0] SelMem  = 3'd7;

  // ALU operation encodings
  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluXor  = 3'b100;
  localparam logic [2:0] AluHold = 3'b101;
  localparam logic [2:0] AluNot  = 3'b110;
  localparam logic [2:0] AluXfer = 3'b111;

  // State
  logic [7:0] r_ar;
  logic [7:0] r_pc;
  logic [7:0] r_dr;
  logic [7:0] r_ac;
  logic [7:0] r_ir;
  logic [7:0] r_tr;
  logic       r_e;
  logic [7:0] r_t;
  logic [7:0] r_mem [256];

  // Combinational signals
  logic [7:0] w_mem_rdata;
  logic [7:0] w_bus;
  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [7:0] w_alu_ac;
  logic       w_alu_e;
  logic [7:0] w_ar_nxt;
  logic [7:0] w_pc_nxt;
  logic [7:0] w_dr_nxt;
  logic [7:0] w_ac_nxt;
  logic [7:0] w_ir_nxt;
  logic [7:0] w_tr_nxt;
  logic       w_e_nxt;
  logic [7:0] w_t_nxt;
  logic       w_t_onehot;

  assign w_mem_rdata = r_mem[r_ar];

  // Bus multiplexer; memory only drives the bus when a read is requested
  always_comb begin
    w_bus = 8'h00;
    unique case (i_bus_selectors)
      SelZero: w_bus = 8'h00;
      SelAr:   w_bus = r_ar;
      SelPc:   w_bus = r_pc;
      SelDr:   w_bus = r_dr;
      SelAc:   w_bus = r_ac;
      SelIr:   w_bus = r_ir;
      SelTr:   w_bus = r_tr;
      SelMem:  w_bus = i_memory_read ? w_mem_rdata : 8'h00;
      default: w_bus = 8'h00;
    endcase
  end

  // Subtraction as AC + ~DR + 1 so the carry out is the "no borrow" flag
  assign w_sum  = {1'b0, r_ac} + {1'b0, r_dr};
  assign w_diff = {1'b0, r_ac} + {1'b0, ~r_dr} + 9'd1;

  // ALU result; logic and transfer modes keep E
  always_comb begin
    w_alu_ac = r_ac;
    w_alu_e  = r_e;
    unique case (i_alu_mode)
      AluAdd: begin
        w_alu_ac = w_sum[7:0];
        w_alu_e  = w_sum[8];
      end
      AluSub: begin
        w_alu_ac = w_diff[7:0];
        w_alu_e  = w_diff[8];
      end
      AluAnd:  w_alu_ac = r_ac & r_dr;
      AluOr:   w_alu_ac = r_ac | r_dr;
      AluXor:  w_alu_ac = r_ac ^ r_dr;
      AluHold: w_alu_ac = r_ac;
      AluNot:  w_alu_ac = ~r_ac;
      AluXfer: w_alu_ac = r_dr;
      default: w_alu_ac = r_ac;
    endcase
  end

  // Register next-state with clear > load > inc priority
  always_comb begin
    w_ar_nxt = r_ar;
    if (i_clear_ar)     w_ar_nxt = 8'h00;
    else if (i_load_ar) w_ar_nxt = w_bus;
    else if (i_inc_ar)  w_ar_nxt = r_ar + 8'd1;

    w_pc_nxt = r_pc;
    if (i_clear_pc)     w_pc_nxt = 8'h00;
    else if (i_load_pc) w_pc_nxt = w_bus;
    else if (i_inc_pc)  w_pc_nxt = r_pc + 8'd1;

    w_dr_nxt = r_dr;
    if (i_clear_dr)     w_dr_nxt = 8'h00;
    else if (i_load_dr) w_dr_nxt = w_bus;
    else if (i_inc_dr)  w_dr_nxt = r_dr + 8'd1;

    w_tr_nxt = r_tr;
    if (i_clear_tr)     w_tr_nxt = 8'h00;
    else if (i_load_tr) w_tr_nxt = w_bus;
    else if (i_inc_tr)  w_tr_nxt = r_tr + 8'd1;

    w_ir_nxt = i_load_ir ? w_bus : r_ir;
  end

  // AC and E next-state: clear > load > ALU > inc; E only moves with the ALU
  always_comb begin
    w_ac_nxt = r_ac;
    w_e_nxt  = r_e;
    if (i_clear_ac) begin
      w_ac_nxt = 8'h00;
    end else if (i_load_ac) begin
      w_ac_nxt = w_bus;
    end else if (i_alu_enable) begin
      w_ac_nxt = w_alu_ac;
      w_e_nxt  = w_alu_e;
    end else if (i_inc_ac) begin
      w_ac_nxt = r_ac + 8'd1;
    end
  end

  // Sequence counter rotate; any non-one-hot value falls back to T0
  assign w_t_onehot = (r_t != 8'h00) && ((r_t & (r_t - 8'd1)) == 8'h00);

  always_comb begin
    w_t_nxt = {r_t[6:0], r_t[7]};
    if (i_seq_counter_reset || !w_t_onehot) w_t_nxt = 8'h01;
  end

  // Register file and sequence counter update; reset dominates every control
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ar <= 8'h00;
      r_pc <= 8'h00;
      r_dr <= 8'h00;
      r_ac <= 8'h00;
      r_ir <= 8'h00;
      r_tr <= 8'h00;
      r_e  <= 1'b0;
      r_t  <= 8'h01;
    end else begin
      r_ar <= w_ar_nxt;
      r_pc <= w_pc_nxt;
      r_dr <= w_dr_nxt;
      r_ac <= w_ac_nxt;
      r_ir <= w_ir_nxt;
      r_tr <= w_tr_nxt;
      r_e  <= w_e_nxt;
      r_t  <= w_t_nxt;
    end
  end

  // Memory write: preload port during reset, bus write at old AR otherwise; never cleared
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (i_prog_we) r_mem[i_prog_addr] <= i_prog_data;
    end else if (i_memory_write) begin
      r_mem[r_ar] <= w_bus;
    end
  end

  assign o_t   = r_t;
  assign o_ir  = r_ir;
  assign o_ac  = r_ac;
  assign o_pc  = r_pc;
  assign o_ar  = r_ar;
  assign o_dr  = r_dr;
  assign o_e   = r_e;
  assign o_bus = w_bus;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed bench for datapath_unit: preload, fetch, ALU, priorities, bus write, sequencing, reset.
module tb_datapath_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_ar, load_pc, load_dr, load_ac, load_ir, load_tr;
  logic       clear_ar, clear_pc, clear_dr, clear_ac, clear_tr;
  logic       inc_ar, inc_pc, inc_dr, inc_ac, inc_tr;
  logic       seq_rst, mem_rd, mem_wr, alu_en, prog_we;
  logic [2:0] bus_sel, alu_mode;
  logic [7:0] prog_addr, prog_data;
  logic [7:0] t, ir, ac, pc, ar, dr, bus;
  logic       e;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  datapath_unit u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_load_ar(load_ar), .i_load_pc(load_pc), .i_load_dr(load_dr),
    .i_load_ac(load_ac), .i_load_ir(load_ir), .i_load_tr(load_tr),
    .i_clear_ar(clear_ar), .i_clear_pc(clear_pc), .i_clear_dr(clear_dr),
    .i_clear_ac(clear_ac), .i_clear_tr(clear_tr),
    .i_inc_ar(inc_ar), .i_inc_pc(inc_pc), .i_inc_dr(inc_dr),
    .i_inc_ac(inc_ac), .i_inc_tr(inc_tr),
    .i_seq_counter_reset(seq_rst), .i_memory_read(mem_rd), .i_memory_write(mem_wr),
    .i_bus_selectors(bus_sel), .i_alu_enable(alu_en), .i_alu_mode(alu_mode),
    .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_data(prog_data),
    .o_t(t), .o_ir(ir), .o_ac(ac), .o_pc(pc), .o_ar(ar), .o_dr(dr), .o_e(e), .o_bus(bus)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
  endtask

  task automatic idle();
    rst = 0; seq_rst = 0; mem_rd = 0; mem_wr = 0; alu_en = 0; prog_we = 0;
    load_ar = 0; load_pc = 0; load_dr = 0; load_ac = 0; load_ir = 0; load_tr = 0;
    clear_ar = 0; clear_pc = 0; clear_dr = 0; clear_ac = 0; clear_tr = 0;
    inc_ar = 0; inc_pc = 0; inc_dr = 0; inc_ac = 0; inc_tr = 0;
    bus_sel = 3'd0; alu_mode = 3'd0; prog_addr = 8'h00; prog_data = 8'h00;
  endtask

  // One clock, then settle past the edge; inputs are left for the caller to clear
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    idle();
  endtask

  // Apply one ALU operation and check AC/E
  task automatic alu_op(input logic [2:0] mode, input logic [7:0] exp_ac, input logic exp_e,
                        input string tag);
    alu_en = 1; alu_mode = mode;
    step();
    check({tag, " ac"}, ac, exp_ac);
    check({tag, " e"}, {7'd0, e}, {7'd0, exp_e});
  endtask

  logic [7:0] preload [8];
  int         guard;

  initial begin
    preload[0] = 8'h12; preload[1] = 8'h34; preload[2] = 8'hF0; preload[3] = 8'h20;
    preload[4] = 8'h05; preload[5] = 8'h00; preload[6] = 8'h77; preload[7] = 8'h55;
    idle();
    rst = 1;
    tick();
    // Preload memory while held in reset
    for (int i = 0; i < 8; i++) begin
      rst = 1; prog_we = 1; prog_addr = 8'(i); prog_data = preload[i];
      tick();
    end
    idle();
    check("rst t", t, 8'h01);
    check("rst ar", ar, 8'h00);
    check("rst pc", pc, 8'h00);
    check("rst ac", ac, 8'h00);
    check("rst ir", ir, 8'h00);
    check("rst dr", dr, 8'h00);
    check("rst e", {7'd0, e}, 8'h00);

    // Free-running sequence counter with wrap
    for (int i = 0; i < 10; i++) begin
      check($sformatf("seq t%0d", i), t, 8'h01 << (i % 8));
      step();
    end
    step();
    check("seq t at 0x08", t, 8'h08);
    seq_rst = 1;
    step();
    check("seq reset", t, 8'h01);
    step();
    check("seq after reset", t, 8'h02);

    // Fetch: AR <- PC, then IR <- mem[AR], PC++
    bus_sel = 3'd2; load_ar = 1;
    step();
    check("fetch ar", ar, 8'h00);
    bus_sel = 3'd7; mem_rd = 0; #1;
    check("bus mem no read", bus, 8'h00);
    mem_rd = 1; load_ir = 1; inc_pc = 1; #1;
    check("bus mem read", bus, 8'h12);
    step();
    check("fetch ir", ir, 8'h12);
    check("fetch pc", pc, 8'h01);

    // AR -> 2, AC <- mem[2] with AR++, DR <- mem[3]
    inc_ar = 1; step(); inc_ar = 1; step();
    bus_sel = 3'd7; mem_rd = 1; load_ac = 1; inc_ar = 1;
    step();
    check("load ac", ac, 8'hF0);
    check("ar inc", ar, 8'h03);
    bus_sel = 3'd7; mem_rd = 1; load_dr = 1;
    step();
    check("load dr", dr, 8'h20);

    // ALU walk with DR = 0x20
    alu_op(3'b000, 8'h10, 1'b1, "add");
    alu_op(3'b101, 8'h10, 1'b1, "hold");
    alu_op(3'b001, 8'hF0, 1'b0, "sub borrow");
    alu_op(3'b001, 8'hD0, 1'b1, "sub no borrow");
    alu_op(3'b010, 8'h00, 1'b1, "and");
    alu_op(3'b011, 8'h20, 1'b1, "or");
    alu_op(3'b100, 8'h00, 1'b1, "xor");
    alu_op(3'b110, 8'hFF, 1'b1, "not");
    alu_op(3'b111, 8'h20, 1'b1, "xfer");

    // Priorities on AC
    bus_sel = 3'd3; load_ac = 1; clear_ac = 1;
    step();
    check("clear over load", ac, 8'h00);
    bus_sel = 3'd3; load_ac = 1; alu_en = 1; alu_mode = 3'b110;
    step();
    check("load over alu", ac, 8'h20);
    alu_en = 1; alu_mode = 3'b110; inc_ac = 1;
    step();
    check("alu over inc", ac, 8'hDF);

    // PC wrap: AC = 0xFF, PC <- AC, PC++
    clear_ac = 1; step();
    alu_en = 1; alu_mode = 3'b110; step();
    bus_sel = 3'd4; load_pc = 1; step();
    check("pc ff", pc, 8'hFF);
    inc_pc = 1; step();
    check("pc wrap", pc, 8'h00);

    // TR <- mem[4] = 5, AC <- mem[6] = 0x77, AR <- TR
    inc_ar = 1; step();
    bus_sel = 3'd7; mem_rd = 1; load_tr = 1; inc_ar = 1; step();
    inc_ar = 1; step();
    bus_sel = 3'd7; mem_rd = 1; load_ac = 1; inc_ar = 1; step();
    check("ac 77", ac, 8'h77);
    bus_sel = 3'd6; load_ar = 1; step();
    check("ar from tr", ar, 8'h05);

    // Write with simultaneous AR load must use old AR
    bus_sel = 3'd4; mem_wr = 1; load_ar = 1; step();
    check("ar after write", ar, 8'h77);
    bus_sel = 3'd6; load_ar = 1; step();
    bus_sel = 3'd7; mem_rd = 1; #1;
    check("mem5 written", bus, 8'h77);
    idle();

    // AC <- mem[7] = 0x55, AR back to 5
    inc_ar = 1; step(); inc_ar = 1; step();
    bus_sel = 3'd7; mem_rd = 1; load_ac = 1; step();
    check("ac 55", ac, 8'h55);
    bus_sel = 3'd6; load_ar = 1; step();

    // Reset mid-sequence at T5 with a competing memory write and register loads
    guard = 0;
    while (t != 8'h20 && guard < 16) begin
      step();
      guard++;
    end
    check("reach t 0x20", t, 8'h20);
    rst = 1; mem_wr = 1; bus_sel = 3'd4; load_ac = 1; inc_pc = 1; alu_en = 1;
    step();
    check("mid rst t", t, 8'h01);
    check("mid rst ac", ac, 8'h00);
    check("mid rst ar", ar, 8'h00);
    check("mid rst pc", pc, 8'h00);
    check("mid rst e", {7'd0, e}, 8'h00);

    // Preload port is ignored out of reset
    prog_we = 1; prog_addr = 8'h00; prog_data = 8'hEE; step();
    bus_sel = 3'd7; mem_rd = 1; #1;
    check("mem0 kept", bus, 8'h12);
    idle();
    for (int i = 0; i < 5; i++) begin
      inc_ar = 1; step();
    end
    bus_sel = 3'd7; mem_rd = 1; #1;
    check("mem5 kept", bus, 8'h77);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/datapath_unit.md
DATAPATH_UNIT -- requirements
Module: datapath_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-003 load_AR/PC/DR/AC/IR/TR  input  1 each  load register from bus.
REQ-004 clear_AR/PC/DR/AC/TR  input  1 each  clear register to 0.
REQ-005 inc_AR/PC/DR/AC/TR  input  1 each  increment register by 1, mod 256.
REQ-006 seq_counter_RESET  input  1  return sequence counter to T0.
REQ-007 memory_read  input  1  drive mem[AR] onto bus when bus_selectors=7.
REQ-008 memory_write  input  1  write bus to mem[AR].
REQ-009 bus_selectors  input  3  bus source: 0 zero, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory.
REQ-010 alu_enable  input  1  apply alu_mode result to AC/E.
REQ-011 alu_mode  input  3  ALU operation select (REQ-020).
REQ-012 prog_we  input  1  memory preload write strobe; honored only while rst=1.
REQ-013 prog_addr  input  8  preload address.
REQ-014 prog_data  input  8  preload data.
REQ-015 T  output  8  one-hot sequence timing, T[0]..T[7].
REQ-016 IR  output  8  instruction register.
REQ-017 AC, PC, AR, DR  output  8 each  register contents.
REQ-018 E  output  1  ALU carry/borrow flag.
REQ-019 bus  output  8  current combinational bus value.

Function
REQ-020 alu_mode: 000 AC+DR (E=carry out), 001 AC-DR (E=1 if no borrow), 010 AC&DR, 011 AC|DR, 100 AC^DR, 101 no change to AC or E, 110 ~AC, 111 AC=DR; logic modes leave E unchanged.
REQ-021 Registers AR, PC, DR, AC, IR, TR 8-bit; all arithmetic modulo 256, 255+1 wraps to 0.
REQ-022 Per-register priority: clear > load > inc; AC additionally: clear > load > alu_enable > inc.
REQ-023 IR has load only; no clear/inc.
REQ-024 Bus combinational from pre-edge register values; sel 7 with memory_read=0 yields 0x00.
REQ-025 Memory 256x8, asynchronous read at AR, synchronous write at rising edge when memory_write=1: mem[AR] <= bus (pre-edge AR and bus).
REQ-026 Simultaneous memory_write and load_AR: write uses old AR.
REQ-027 Loads from bus sel 7 sample mem[AR] before any same-cycle write.
REQ-028 Sequence counter: one-hot T, advances T[i]->T[i+1] each cycle; T[7]->T[0] wrap.
REQ-029 seq_counter_RESET=1: next T = 8'b0000_0001, overriding advance.
REQ-030 T SHALL always be exactly one-hot.
REQ-031 All outputs except bus are registered; control effects visible one cycle after assertion.

Reset
REQ-032 rst=1: AR, PC, DR, AC, IR, TR, E cleared to 0; T = 8'b0000_0001; dominates all control inputs.
REQ-033 Memory contents SHALL NOT be cleared by rst; preserved across reset.
REQ-034 While rst=1 and prog_we=1: mem[prog_addr] <= prog_data; memory_write ignored during rst.
REQ-035 prog_we ignored while rst=0.
REQ-036 Reset asserted mid-sequence: next cycle all state per REQ-032, no partial update.

Verification
REQ-037 rst with prog_we writes 0x12 to addr 0, 0x34 to addr 1; release; bus_sel=2, load_AR; next bus_sel=7, memory_read, load_IR, inc_PC -> IR=0x12, PC=1.
REQ-038 AC=0xF0, DR=0x20, alu_enable, mode 000 -> AC=0x10, E=1; mode 101 -> AC, E unchanged.
REQ-039 load_AC and clear_AC same cycle -> AC=0; inc_PC at PC=0xFF -> PC=0x00.
REQ-040 AR=0x05, AC=0x77, bus_sel=4, memory_write, load_AR same cycle -> mem[0x05]=0x77, AR=0x77.
REQ-041 Free-run 10 cycles from reset -> T goes 0x01,0x02,...,0x80,0x01,0x02; seq_counter_RESET at T=0x08 -> next T=0x01.
REQ-042 rst asserted with T=0x20, AC=0x55 -> next cycle T=0x01, AC=0, memory unchanged.
